// File: rtl/ws281x_pkg.sv
// Shared definitions for the WS281x serial receiver and driver:
// FSM state encoding, word geometry and pulse-counter limits.
package ws281x_pkg;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t ST_IDLE = 2'd0;
    localparam rx_state_t ST_ARM  = 2'd1;
    localparam rx_state_t ST_HIGH = 2'd2;
    localparam rx_state_t ST_LOW  = 2'd3;

    localparam int unsigned BITS_PER_WORD = 24;
    localparam logic [4:0]  BIT_CNT_LAST  = 5'(BITS_PER_WORD - 1);
    localparam logic [9:0]  HI_CNT_SAT    = 10'd1023;

    // A zero gap length would never be "reached"; the shortest usable gap is one cycle.
    function automatic logic [15:0] eff_reset_period(input logic [15:0] period);
        return (period == 16'd0) ? 16'd1 : period;
    endfunction

endpackage

// File: rtl/ws281x_rx_fifo.sv
// Show-ahead FIFO for received GRB words; the head is visible on rdata while
// not empty and reads as zero when empty.
module ws281x_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             mclk,
    input  logic             h_reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/ws281x_rx.sv
// WS281x serial receiver: synchronizes rxd, measures high-pulse widths to
// decode bits, assembles 24-bit GRB words and buffers them in a FIFO.
module ws281x_rx
    import ws281x_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        mclk,
    input  logic        h_reset_n,
    input  logic        rxd,
    input  logic        cfg_rx_enb,
    input  logic [9:0]  cfg_th_thresh,
    input  logic [15:0] cfg_reset_period,
    input  logic        rx_rd,
    input  logic        rx_ovf_clr,
    output logic [23:0] rx_data,
    output logic        rx_dval,
    output logic        rx_ovf,
    output logic        rx_bit_err,
    output logic        rx_frame_done
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rxd_dly_q, rxd_dly_d;
    rx_state_t              state_q, state_d;
    logic [9:0]             hi_cnt_q, hi_cnt_d;
    logic [15:0]            lo_cnt_q, lo_cnt_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [23:0]            sr_q, sr_d;
    logic                   push_q, push_d;
    logic                   word_seen_q, word_seen_d;
    logic                   bit_err_q, bit_err_d;
    logic                   frame_done_q, frame_done_d;
    logic                   ovf_q, ovf_d;

    logic        rxd_s;
    logic        rise;
    logic        fall;
    logic [15:0] period;
    logic [15:0] lo_inc;
    logic [9:0]  hi_inc;
    logic        gap_reached;
    logic        rx_bit;
    logic        fifo_full;
    logic        fifo_empty;

    assign sync_d    = {sync_q[SYNC_STAGES-2:0], rxd};
    assign rxd_s     = sync_q[SYNC_STAGES-1];
    assign rxd_dly_d = rxd_s;
    assign rise      = rxd_s & ~rxd_dly_q;
    assign fall      = ~rxd_s & rxd_dly_q;

    assign period = eff_reset_period(cfg_reset_period);
    assign lo_inc = (lo_cnt_q == 16'hFFFF) ? lo_cnt_q : lo_cnt_q + 16'd1;
    assign hi_inc = (hi_cnt_q == HI_CNT_SAT) ? hi_cnt_q : hi_cnt_q + 10'd1;
    // True only on the cycle the low count first crosses the gap length.
    assign gap_reached = (lo_cnt_q < period) && (lo_inc >= period);
    assign rx_bit      = (hi_cnt_q > cfg_th_thresh);

    always_comb begin
        state_d      = state_q;
        hi_cnt_d     = hi_cnt_q;
        lo_cnt_d     = lo_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        sr_d         = sr_q;
        word_seen_d  = word_seen_q;
        push_d       = 1'b0;
        bit_err_d    = 1'b0;
        frame_done_d = 1'b0;

        if (!cfg_rx_enb) begin
            state_d     = ST_IDLE;
            hi_cnt_d    = '0;
            lo_cnt_d    = '0;
            bit_cnt_d   = '0;
            sr_d        = '0;
            word_seen_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_ARM;
                    lo_cnt_d  = '0;
                    bit_cnt_d = '0;
                    sr_d      = '0;
                end
                // Wait for a full latch gap so decoding never starts mid-word.
                ST_ARM: begin
                    if (rxd_s) begin
                        lo_cnt_d = '0;
                    end else begin
                        lo_cnt_d = lo_inc;
                        if (lo_inc >= period) begin
                            state_d     = ST_LOW;
                            bit_cnt_d   = '0;
                            sr_d        = '0;
                            word_seen_d = 1'b0;
                        end
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        hi_cnt_d = '0;
                        state_d  = ST_HIGH;
                    end else begin
                        lo_cnt_d = lo_inc;
                        if (gap_reached) begin
                            if (bit_cnt_q != 5'd0) begin
                                bit_err_d = 1'b1;
                                bit_cnt_d = '0;
                                sr_d      = '0;
                            end else if (word_seen_q) begin
                                frame_done_d = 1'b1;
                                word_seen_d  = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    if (fall) begin
                        sr_d     = {sr_q[22:0], rx_bit};
                        lo_cnt_d = '0;
                        state_d  = ST_LOW;
                        if (bit_cnt_q == BIT_CNT_LAST) begin
                            bit_cnt_d   = '0;
                            push_d      = 1'b1;
                            word_seen_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        hi_cnt_d = hi_inc;
                        if ((hi_inc == HI_CNT_SAT) && (hi_cnt_q != HI_CNT_SAT)) begin
                            bit_err_d = 1'b1;
                            bit_cnt_d = '0;
                            sr_d      = '0;
                            lo_cnt_d  = '0;
                            state_d   = ST_ARM;
                        end
                    end
                end
            endcase
        end
    end

    // Sticky overflow: a set in the same cycle as a clear wins.
    assign ovf_d = (ovf_q & ~rx_ovf_clr) | (push_q & fifo_full & ~rx_rd);

    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            sync_q       <= '0;
            rxd_dly_q    <= 1'b0;
            state_q      <= ST_IDLE;
            hi_cnt_q     <= '0;
            lo_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            sr_q         <= '0;
            push_q       <= 1'b0;
            word_seen_q  <= 1'b0;
            bit_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            rxd_dly_q    <= rxd_dly_d;
            state_q      <= state_d;
            hi_cnt_q     <= hi_cnt_d;
            lo_cnt_q     <= lo_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            sr_q         <= sr_d;
            push_q       <= push_d;
            word_seen_q  <= word_seen_d;
            bit_err_q    <= bit_err_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
        end
    end

    ws281x_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (24)
    ) u_fifo (
        .mclk      (mclk),
        .h_reset_n (h_reset_n),
        .push      (push_q),
        .wdata     (sr_q),
        .pop       (rx_rd),
        .rdata     (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_dval       = ~fifo_empty;
    assign rx_ovf        = ovf_q;
    assign rx_bit_err    = bit_err_q;
    assign rx_frame_done = frame_done_q;

endmodule

// File: tb/tb_ws281x_rx.sv
// Scoreboard bench for ws281x_rx: stimulus queues expected words, a monitor
// pops and compares whenever the receiver presents data.
module tb_ws281x_rx;

    localparam int SYNC_STAGES = 2;
    localparam int FIFO_DEPTH  = 4;

    logic        mclk = 1'b0;
    logic        h_reset_n;
    logic        rxd;
    logic        cfg_rx_enb;
    logic [9:0]  cfg_th_thresh;
    logic [15:0] cfg_reset_period;
    logic        rx_rd;
    logic        rx_ovf_clr;
    logic [23:0] rx_data;
    logic        rx_dval;
    logic        rx_ovf;
    logic        rx_bit_err;
    logic        rx_frame_done;

    int          n_checks    = 0;
    int          n_errors    = 0;
    int          cyc         = 0;
    int          fall_cyc    = 0;
    int          n_err_pulse = 0;
    int          n_fd        = 0;
    bit          lat_chk     = 1'b0;
    bit          auto_rd     = 1'b1;
    logic [23:0] exp_q[$];

    ws281x_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .mclk             (mclk),
        .h_reset_n        (h_reset_n),
        .rxd              (rxd),
        .cfg_rx_enb       (cfg_rx_enb),
        .cfg_th_thresh    (cfg_th_thresh),
        .cfg_reset_period (cfg_reset_period),
        .rx_rd            (rx_rd),
        .rx_ovf_clr       (rx_ovf_clr),
        .rx_data          (rx_data),
        .rx_dval          (rx_dval),
        .rx_ovf           (rx_ovf),
        .rx_bit_err       (rx_bit_err),
        .rx_frame_done    (rx_frame_done)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops every presented word and compares it with the queue head.
    initial begin
        logic [23:0] exp_w;
        rx_rd = 1'b0;
        forever begin
            @(negedge mclk);
            if (auto_rd && rx_dval && h_reset_n) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got %06h expected none", rx_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("word", {8'h0, rx_data}, {8'h0, exp_w});
                    if (lat_chk) begin
                        check("latency", cyc - fall_cyc, SYNC_STAGES + 2);
                        lat_chk = 1'b0;
                    end
                end
                rx_rd = 1'b1;
            end else begin
                rx_rd = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge mclk);
            if (rx_bit_err)    n_err_pulse++;
            if (rx_frame_done) n_fd++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b);
        rxd = 1'b1;
        repeat (b ? 45 : 20) @(negedge mclk);
        rxd      = 1'b0;
        fall_cyc = cyc;
        repeat (b ? 25 : 50) @(negedge mclk);
    endtask

    task automatic send_range(input logic [23:0] w, input int msb, input int lsb, input bit expect_it);
        if (expect_it) exp_q.push_back(w);
        for (int i = msb; i >= lsb; i--) send_bit(w[i]);
    endtask

    task automatic gap(input int n);
        rxd = 1'b0;
        repeat (n) @(negedge mclk);
    endtask

    initial begin
        int e0;
        int f0;
        h_reset_n        = 1'b0;
        rxd              = 1'b0;
        cfg_rx_enb       = 1'b0;
        cfg_th_thresh    = 10'd30;
        cfg_reset_period = 16'd500;
        rx_ovf_clr       = 1'b0;
        repeat (3) @(negedge mclk);
        check("rst_dval", {31'h0, rx_dval}, 0);
        check("rst_data", {8'h0, rx_data}, 0);
        check("rst_ovf", {31'h0, rx_ovf}, 0);
        check("rst_bit_err", {31'h0, rx_bit_err}, 0);
        check("rst_frame_done", {31'h0, rx_frame_done}, 0);
        h_reset_n  = 1'b1;
        cfg_rx_enb = 1'b1;

        // Basic word with latency measurement and frame end.
        gap(600);
        e0 = n_err_pulse; f0 = n_fd;
        lat_chk = 1'b1;
        send_range(24'hFF0055, 23, 0, 1'b1);
        gap(600);
        check("t1_latency_seen", {31'h0, lat_chk}, 0);
        check("t1_frame_done", n_fd - f0, 1);
        check("t1_bit_err", n_err_pulse - e0, 0);
        check("t1_queue", exp_q.size(), 0);

        // Enable mid-word: that word is ignored, the next one after a gap decodes.
        cfg_rx_enb = 1'b0;
        repeat (5) @(negedge mclk);
        e0 = n_err_pulse; f0 = n_fd;
        send_range(24'h123456, 23, 14, 1'b0);
        cfg_rx_enb = 1'b1;
        send_range(24'h123456, 13, 0, 1'b0);
        gap(600);
        send_range(24'hA5C3F0, 23, 0, 1'b1);
        gap(600);
        check("t2_frame_done", n_fd - f0, 1);
        check("t2_bit_err", n_err_pulse - e0, 0);
        check("t2_queue", exp_q.size(), 0);

        // Overflow: five words into a four-entry FIFO with no reads.
        auto_rd = 1'b0;
        f0 = n_fd;
        send_range(24'h111111, 23, 0, 1'b1);
        send_range(24'h222222, 23, 0, 1'b1);
        send_range(24'h333333, 23, 0, 1'b1);
        send_range(24'h444444, 23, 0, 1'b1);
        send_range(24'h555555, 23, 0, 1'b0);
        gap(600);
        check("t3_ovf_set", {31'h0, rx_ovf}, 1);
        check("t3_dval", {31'h0, rx_dval}, 1);
        check("t3_head", {8'h0, rx_data}, 32'h111111);
        check("t3_frame_done", n_fd - f0, 1);
        auto_rd = 1'b1;
        repeat (20) @(negedge mclk);
        check("t3_queue", exp_q.size(), 0);
        check("t3_ovf_sticky", {31'h0, rx_ovf}, 1);
        rx_ovf_clr = 1'b1;
        @(negedge mclk);
        rx_ovf_clr = 1'b0;
        check("t3_ovf_clr", {31'h0, rx_ovf}, 0);

        // Partial word ended by a gap.
        e0 = n_err_pulse; f0 = n_fd;
        send_range(24'hC0FFEE, 23, 12, 1'b0);
        gap(600);
        check("t4_bit_err", n_err_pulse - e0, 1);
        check("t4_frame_done", n_fd - f0, 0);

        // Stuck-high line saturates the high counter, then recovery.
        e0 = n_err_pulse; f0 = n_fd;
        rxd = 1'b1;
        repeat (1100) @(negedge mclk);
        check("t5_bit_err", n_err_pulse - e0, 1);
        gap(600);
        send_range(24'h0F0F0F, 23, 0, 1'b1);
        gap(600);
        check("t5_frame_done", n_fd - f0, 1);
        check("t5_bit_err_once", n_err_pulse - e0, 1);
        check("t5_queue", exp_q.size(), 0);

        // Reset during bit 20 loses buffered and partial data.
        auto_rd = 1'b0;
        send_range(24'hDEAD01, 23, 0, 1'b0);
        check("t6_dval_before", {31'h0, rx_dval}, 1);
        check("t6_head_before", {8'h0, rx_data}, 32'hDEAD01);
        send_range(24'h765432, 23, 4, 1'b0);
        rxd = 1'b1;
        repeat (10) @(negedge mclk);
        h_reset_n = 1'b0;
        #2;
        check("t6_rst_dval", {31'h0, rx_dval}, 0);
        check("t6_rst_data", {8'h0, rx_data}, 0);
        check("t6_rst_ovf", {31'h0, rx_ovf}, 0);
        check("t6_rst_bit_err", {31'h0, rx_bit_err}, 0);
        check("t6_rst_frame_done", {31'h0, rx_frame_done}, 0);
        repeat (3) @(negedge mclk);
        rxd = 1'b0;
        @(negedge mclk);
        h_reset_n = 1'b1;
        auto_rd   = 1'b1;
        f0 = n_fd;
        gap(600);
        send_range(24'h00FF00, 23, 0, 1'b1);
        gap(600);
        check("t6_frame_done", n_fd - f0, 1);
        check("t6_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ws281x_rx.md
WS281X_RX -- requirements
Module: ws281x_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of input synchronizer flops on rxd (min 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the number of received-word entries (power of 2, min 2).
REQ-003 mclk  input  1  sole clock; all state on rising edge.
REQ-004 h_reset_n  input  1  asynchronous, active-low reset.
REQ-005 rxd  input  1  asynchronous WS281x serial line from the LED chain or a loop-back of a driver's txd.
REQ-006 cfg_rx_enb  input  1  receiver enable; low forces the FSM to IDLE.
REQ-007 cfg_th_thresh  input  10  high-pulse length in mclk cycles; a length above it decodes as 1, otherwise 0.
REQ-008 cfg_reset_period  input  16  low-time in mclk cycles that marks the latch/reset gap.
REQ-009 rx_rd  input  1  single-cycle pop of the FIFO head.
REQ-010 rx_ovf_clr  input  1  clears rx_ovf.
REQ-011 rx_data  output  24  FIFO head, {green[23:16], red[15:8], blue[7:0]}, show-ahead.
REQ-012 rx_dval  output  1  FIFO not empty.
REQ-013 rx_ovf  output  1  sticky: a word was dropped because the FIFO was full.
REQ-014 rx_bit_err  output  1  one-cycle pulse: a partial word was discarded or a high pulse saturated.
REQ-015 rx_frame_done  output  1  one-cycle pulse when a latch gap ends a frame of at least one word.

Function
REQ-016 rxd SHALL pass through SYNC_STAGES flops, with all reset to 0; edge detection SHALL use the synchronized value plus one more delayed flop.
REQ-017 The FSM states SHALL be IDLE, ARM, HIGH and LOW.
REQ-018 IDLE: when cfg_rx_enb=1, go to ARM.
REQ-019 ARM: count synchronized-low cycles and restart the count on any high; once the count reaches cfg_reset_period, go to LOW with the bit count at 0. This gives gap alignment, so a mid-stream start is never decoded.
REQ-020 LOW: on a rising edge, clear the high counter and go to HIGH; the low counter SHALL increment each cycle.
REQ-021 In LOW, when the low counter reaches cfg_reset_period with bit count 0 and at least one word received since the last gap, pulse rx_frame_done.
REQ-022 In LOW, when the low counter reaches cfg_reset_period with bit count non-zero, discard the partial word, pulse rx_bit_err and clear the bit count.
REQ-023 HIGH: the high counter SHALL increment each cycle and saturate at 1023.
REQ-024 HIGH: on a falling edge, shift in bit = (high count > cfg_th_thresh), MSB first, increment the bit count, clear the low counter and go to LOW.
REQ-025 HIGH: reaching the 1023 saturation SHALL pulse rx_bit_err, discard the partial word and go to ARM.
REQ-026 When the 24th bit is shifted in, the assembled word SHALL be pushed the following cycle and the bit count SHALL wrap to 0.
REQ-027 Latency from the rxd falling edge (at the pin) of the 24th bit to rx_dval=1 on an empty FIFO SHALL be SYNC_STAGES+2 cycles.
REQ-028 Push onto a full FIFO without a simultaneous pop: drop the word and set rx_ovf; rx_ovf SHALL hold until rx_ovf_clr, and a simultaneous set and clear leaves it set.
REQ-029 Simultaneous push and pop on a full FIFO SHALL accept both, with occupancy unchanged.
REQ-030 rx_rd while the FIFO is empty SHALL be ignored, with no pointer movement.
REQ-031 cfg_rx_enb falling mid-word SHALL return the FSM to IDLE next cycle and discard the partial word without rx_bit_err; FIFO contents SHALL be retained.
REQ-032 Counter compares SHALL be unsigned; cfg_reset_period=0 SHALL be treated as 1.

Reset
REQ-033 On h_reset_n low, asynchronously: FSM=IDLE; all counters, pointers and the shift register =0; rx_data=0; rx_dval, rx_ovf, rx_bit_err and rx_frame_done =0.
REQ-034 Deassertion SHALL take effect on the next mclk edge; reset mid-frame SHALL lose all partial and buffered data.

Structure
REQ-035 The FSM state enum, bit-per-word constant (24) and high-counter saturation value (1023) SHALL live in a shared package ws281x_pkg, also usable by ws281x_driver.
REQ-036 The FIFO SHALL be a separate sub-module ws281x_rx_fifo (24-bit, FIFO_DEPTH, show-ahead, full/empty outputs).

Verification
REQ-037 th=30, reset=500: after a 600-cycle low, send 0xFF0055 as 1=45 high/25 low and 0=20 high/50 low -> rx_dval set, rx_data=0xFF0055, then rx_frame_done after 500 low cycles.
REQ-038 Enable mid-stream during bit 10 of a word -> no word pushed until after the next gap; next full word decoded correctly.
REQ-039 Send 5 words with no rx_rd, FIFO_DEPTH=4 -> 4 words held in order, rx_ovf=1; rx_ovf_clr -> 0.
REQ-040 Send 12 bits then hold low for 500 cycles -> rx_bit_err pulse, no push, no rx_frame_done.
REQ-041 Hold rxd high for 1100 cycles -> rx_bit_err pulse, FSM in ARM; a following gap plus word decodes correctly.
REQ-042 Drive h_reset_n low during bit 20 -> all outputs 0; the next frame after the gap decodes correctly.
